// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
//   Shared definitions for the RV32I decode stage:
//     - 7-bit major opcode constants
//     - alu_op_e     : operation requested from the execute-stage ALU
//     - imm_fmt_e    : immediate encoding format of an instruction
//     - ctrl_t       : packed control bundle carried into EX
//     - imm_fmt_of() : opcode -> immediate format
//     - alu_op_of()  : funct3/funct7[5] -> ALU operation
// ---------------------------------------------------------------------------
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // ALU_ADD is deliberately encoded as zero so an all-zero ctrl_t is a NOP.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

  // FENCE and unknown opcodes carry no immediate (imm = 0).
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // alt is instr[30]; it only selects SUB for register-register ops, since
  // an ADDI immediate may legitimately have that bit set.
  function automatic alu_op_e alu_op_of(input logic [2:0] funct3,
                                        input logic       alt,
                                        input logic       is_reg_op);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//   Combinational RV32I immediate generator. The format is derived from the
//   opcode field; the result is sign-extended to 32 bits. R-type, FENCE and
//   unknown opcodes produce zero.
//   Ports:
//     instr  in   32  instruction word
//     imm    out  32  sign-extended immediate
// ---------------------------------------------------------------------------
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Select and assemble the immediate for the instruction's encoding format.
  always_comb begin
    imm = 32'd0;
    case (imm_fmt_of(instr[6:0]))
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   RV32I instruction decode stage. Two register stages:
//     ID register : id_valid / id_instr / id_pc, loaded from fetch
//     EX register : ex_* outputs, loaded from the decode of the ID register
//   Accept-to-ex_valid latency is two cycles.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     if_valid/if_instr/if_pc     instruction offered by fetch
//     if_ready                    stage accepts the offered instruction
//     rs1_addr/rs2_addr           combinational register-file read addresses
//     rs1_data/rs2_data           register-file read data (already bypassed)
//     stall_id                    hold ID and EX contents
//     flush_id                    discard the instruction entering ID
//     flush_ex                    load a bubble into EX
//     ex_valid, ex_pc, ex_imm     registered EX state
//     ex_rs1_data/ex_rs2_data     registered operands
//     ex_rs1_addr/ex_rs2_addr     registered source indices (forwarding)
//     ex_rd_addr                  registered destination index
//     ex_ctrl                     registered control bundle
// ---------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stall_id,
  input  logic            flush_id,
  input  logic            flush_ex,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [4:0]      ex_rd_addr,
  output ctrl_t           ex_ctrl
);

  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_field;
  logic [4:0]      rs1_field;
  logic [4:0]      rs2_field;

  ctrl_t           dec_ctrl;
  logic [4:0]      dec_rd;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [31:0]     dec_imm;

  assign if_ready  = !stall_id;

  assign opcode    = id_instr[6:0];
  assign rd_field  = id_instr[11:7];
  assign funct3    = id_instr[14:12];
  assign rs1_field = id_instr[19:15];
  assign rs2_field = id_instr[24:20];

  // ID register: flush beats stall; otherwise follow fetch every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= 32'd0;
      id_pc    <= {XLEN{1'b0}};
    end else if (flush_id) begin
      id_valid <= 1'b0;
      id_instr <= 32'd0;
      id_pc    <= {XLEN{1'b0}};
    end else if (!stall_id) begin
      id_valid <= if_valid;
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end
  end

  imm_gen u_imm_gen (
    .instr (id_instr),
    .imm   (dec_imm)
  );

  // Main decoder: control bundle, destination and which sources are read.
  // A bubble in ID decodes to an all-zero NOP that reads and writes nothing.
  always_comb begin
    dec_ctrl = CTRL_NOP;
    dec_rd   = 5'd0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    if (id_valid) begin
      case (opcode)
        OPC_LUI: begin
          dec_ctrl.alu_op      = ALU_PASS_B;
          dec_ctrl.alu_src_imm = 1'b1;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
        end
        OPC_AUIPC: begin
          dec_ctrl.alu_op      = ALU_ADD;
          dec_ctrl.alu_src_imm = 1'b1;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
        end
        OPC_JAL: begin
          dec_ctrl.jump        = 1'b1;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
        end
        OPC_JALR: begin
          dec_ctrl.jump        = 1'b1;
          dec_ctrl.alu_src_imm = 1'b1;
          dec_ctrl.funct3      = funct3;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
          uses_rs1             = 1'b1;
        end
        OPC_BRANCH: begin
          // Comparison is done by subtraction; funct3 picks the condition.
          dec_ctrl.alu_op      = ALU_SUB;
          dec_ctrl.branch      = 1'b1;
          dec_ctrl.funct3      = funct3;
          uses_rs1             = 1'b1;
          uses_rs2             = 1'b1;
        end
        OPC_LOAD: begin
          dec_ctrl.alu_src_imm = 1'b1;
          dec_ctrl.mem_read    = 1'b1;
          dec_ctrl.funct3      = funct3;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
          uses_rs1             = 1'b1;
        end
        OPC_STORE: begin
          dec_ctrl.alu_src_imm = 1'b1;
          dec_ctrl.mem_write   = 1'b1;
          dec_ctrl.funct3      = funct3;
          uses_rs1             = 1'b1;
          uses_rs2             = 1'b1;
        end
        OPC_OP_IMM: begin
          dec_ctrl.alu_op      = alu_op_of(funct3, id_instr[30], 1'b0);
          dec_ctrl.alu_src_imm = 1'b1;
          dec_ctrl.funct3      = funct3;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
          uses_rs1             = 1'b1;
        end
        OPC_OP: begin
          dec_ctrl.alu_op      = alu_op_of(funct3, id_instr[30], 1'b1);
          dec_ctrl.funct3      = funct3;
          dec_ctrl.reg_write   = 1'b1;
          dec_rd               = rd_field;
          uses_rs1             = 1'b1;
          uses_rs2             = 1'b1;
        end
        OPC_MISC_MEM: begin
          // FENCE: in-order single-issue pipe, nothing to order -> NOP.
          dec_ctrl = CTRL_NOP;
        end
        default: begin
          // SYSTEM and every unrecognised opcode.
          dec_ctrl.illegal = 1'b1;
        end
      endcase
    end else begin
      dec_ctrl = CTRL_NOP;
      dec_rd   = 5'd0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  assign rs1_addr = uses_rs1 ? rs1_field : 5'd0;
  assign rs2_addr = uses_rs2 ? rs2_field : 5'd0;

  // EX register: flush_ex inserts a bubble even while stalled (load-use),
  // a plain stall freezes everything, otherwise the ID decode moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= {XLEN{1'b0}};
      ex_imm      <= {XLEN{1'b0}};
      ex_rs1_data <= {XLEN{1'b0}};
      ex_rs2_data <= {XLEN{1'b0}};
      ex_rs1_addr <= 5'd0;
      ex_rs2_addr <= 5'd0;
      ex_rd_addr  <= 5'd0;
      ex_ctrl     <= CTRL_NOP;
    end else if (flush_ex) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_NOP;
      ex_rd_addr  <= 5'd0;
    end else if (!stall_id) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_imm      <= dec_imm;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_rs1_addr <= rs1_addr;
      ex_rs2_addr <= rs2_addr;
      ex_rd_addr  <= dec_rd;
      ex_ctrl     <= dec_ctrl;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage. Expected EX contents for every accepted
//   instruction are pushed to a queue at the accepting edge and popped when
//   the instruction moves into EX. The register file is modelled as a fixed
//   pattern of the read address so captured operands reveal the addresses.
// ---------------------------------------------------------------------------
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    ctrl_t       ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        stall_id, flush_id, flush_ex;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  ctrl_t       ex_ctrl;

  int n_vec = 0;
  int n_err = 0;

  exp_t sbq[$];
  exp_t cur;

  always #5 clk = ~clk;

  assign rs1_data = {16'hA5A5, 11'd0, rs1_addr};
  assign rs2_data = {16'h5A5A, 11'd0, rs2_addr};

  decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .stall_id    (stall_id),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_rs1_addr (ex_rs1_addr),
    .ex_rs2_addr (ex_rs2_addr),
    .ex_rd_addr  (ex_rd_addr),
    .ex_ctrl     (ex_ctrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // flags = {alu_src_imm, mem_read, mem_write, reg_write, branch, jump, illegal}
  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input alu_op_e op,
                              input logic [2:0] f3, input logic [6:0] flags);
    exp_t e;
    e.instr = instr;
    e.pc    = 32'd0;
    e.imm   = imm;
    e.rd    = rd;
    e.rs1   = rs1;
    e.rs2   = rs2;
    e.rs1d  = {16'hA5A5, 11'd0, rs1};
    e.rs2d  = {16'h5A5A, 11'd0, rs2};
    e.ctrl.alu_op      = op;
    e.ctrl.alu_src_imm = flags[6];
    e.ctrl.mem_read    = flags[5];
    e.ctrl.mem_write   = flags[4];
    e.ctrl.funct3      = f3;
    e.ctrl.reg_write   = flags[3];
    e.ctrl.branch      = flags[2];
    e.ctrl.jump        = flags[1];
    e.ctrl.illegal     = flags[0];
    return e;
  endfunction

  function automatic exp_t tab(input int k, input logic [31:0] pc);
    exp_t e;
    case (k)
      0:  e = mk(32'hFFD08293, 32'hFFFFFFFD, 5'd5,  5'd1,  5'd0, ALU_ADD,    3'd0, 7'b1001000); // addi x5,x1,-3
      1:  e = mk(32'hFE208EE3, 32'hFFFFFFFC, 5'd0,  5'd1,  5'd2, ALU_SUB,    3'd0, 7'b0000100); // beq x1,x2,-4
      2:  e = mk(32'h12345537, 32'h12345000, 5'd10, 5'd0,  5'd0, ALU_PASS_B, 3'd0, 7'b1001000); // lui x10
      3:  e = mk(32'h00312423, 32'h00000008, 5'd0,  5'd2,  5'd3, ALU_ADD,    3'd2, 7'b1010000); // sw x3,8(x2)
      4:  e = mk(32'h010000EF, 32'h00000010, 5'd1,  5'd0,  5'd0, ALU_ADD,    3'd0, 7'b0001010); // jal x1,+16
      5:  e = mk(32'h409403B3, 32'h00000000, 5'd7,  5'd8,  5'd9, ALU_SUB,    3'd0, 7'b0001000); // sub x7,x8,x9
      6:  e = mk(32'hFFF22303, 32'hFFFFFFFF, 5'd6,  5'd4,  5'd0, ALU_ADD,    3'd2, 7'b1101000); // lw x6,-1(x4)
      7:  e = mk(32'h80000117, 32'h80000000, 5'd2,  5'd0,  5'd0, ALU_ADD,    3'd0, 7'b1001000); // auipc x2
      8:  e = mk(32'h40365593, 32'h00000403, 5'd11, 5'd12, 5'd0, ALU_SRA,    3'd5, 7'b1001000); // srai x11,x12,3
      10: e = mk(32'h00000073, 32'h00000000, 5'd0,  5'd0,  5'd0, ALU_ADD,    3'd0, 7'b0000001); // ecall
      11: e = mk(32'h00000000, 32'h00000000, 5'd0,  5'd0,  5'd0, ALU_ADD,    3'd0, 7'b0000001); // all-zero word
      12: e = mk(32'h004280E7, 32'h00000004, 5'd1,  5'd5,  5'd0, ALU_ADD,    3'd0, 7'b1001010); // jalr x1,4(x5)
      default: e = mk(32'h0FF0000F, 32'h00000000, 5'd0, 5'd0, 5'd0, ALU_ADD, 3'd0, 7'b0000000); // fence
    endcase
    e.pc = pc;
    return e;
  endfunction

  // Scoreboard model state (ID occupancy and expected ex_valid).
  logic m_id_v = 1'b0;
  logic m_ex_v = 1'b0;
  logic do_cmp;
  logic s_s, s_f, s_fi, s_v, s_r;
  exp_t pend;
  exp_t drop;

  // Edge monitor: advance the model with the inputs seen at the edge, then
  // compare EX just after it.
  always @(posedge clk) begin
    s_s = stall_id; s_f = flush_ex; s_fi = flush_id; s_v = if_valid; s_r = rst;
    do_cmp = 1'b0;
    if (s_r) begin
      sbq.delete();
      m_id_v = 1'b0;
      m_ex_v = 1'b0;
    end else begin
      if (s_f) begin
        m_ex_v = 1'b0;
        if (m_id_v && !s_s && sbq.size() > 0) drop = sbq.pop_front();
      end else if (!s_s) begin
        m_ex_v = m_id_v;
        if (m_id_v) begin
          if (sbq.size() > 0) begin
            pend   = sbq.pop_front();
            do_cmp = 1'b1;
          end else begin
            chk("sb_underflow", 32'd0, 32'd1);
          end
        end
      end
      if (s_fi) m_id_v = 1'b0;
      else if (!s_s) begin
        m_id_v = s_v;
        if (s_v) sbq.push_back(cur);
      end
    end
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_v});
    if (do_cmp) begin
      chk("ex_pc",       ex_pc,       pend.pc);
      chk("ex_imm",      ex_imm,      pend.imm);
      chk("ex_rd_addr",  {27'd0, ex_rd_addr},  {27'd0, pend.rd});
      chk("ex_rs1_addr", {27'd0, ex_rs1_addr}, {27'd0, pend.rs1});
      chk("ex_rs2_addr", {27'd0, ex_rs2_addr}, {27'd0, pend.rs2});
      chk("ex_rs1_data", ex_rs1_data, pend.rs1d);
      chk("ex_rs2_data", ex_rs2_data, pend.rs2d);
      chk("ex_ctrl",     32'(ex_ctrl), 32'(pend.ctrl));
    end
  end

  task automatic drive(input int k, input logic [31:0] pc);
    cur      = tab(k, pc);
    if_valid = 1'b1;
    if_instr = cur.instr;
    if_pc    = pc;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
  endtask

  task automatic issue(input int k, input logic [31:0] pc);
    @(negedge clk);
    drive(k, pc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if_valid = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    stall_id = 1'b0; flush_id = 1'b0; flush_ex = 1'b0;
    cur = tab(9, 32'd0);

    // Reset state
    after_edge();
    after_edge();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_ctrl",  32'(ex_ctrl), 32'd0);
    chk("rst_ex_pc",    ex_pc, 32'd0);
    chk("rst_ex_rd",    {27'd0, ex_rd_addr}, 32'd0);
    chk("rst_rs1_addr", {27'd0, rs1_addr}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // addi x5,x1,-3: ID after one edge, EX after two
    issue(0, 32'h0000_0100);
    after_edge();
    chk("addi_rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("addi_rs2_addr", {27'd0, rs2_addr}, 32'd0);
    idle(1);
    after_edge();
    chk("addi_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_rd",       {27'd0, ex_rd_addr}, 32'd5);
    chk("addi_imm",      ex_imm, 32'hFFFFFFFD);
    chk("addi_rw",       {31'd0, ex_ctrl.reg_write}, 32'd1);
    chk("addi_srcimm",   {31'd0, ex_ctrl.alu_src_imm}, 32'd1);

    // beq x1,x2,-4
    issue(1, 32'h0000_0200);
    idle(1);
    after_edge();
    chk("beq_imm",    ex_imm, 32'hFFFFFFFC);
    chk("beq_branch", {31'd0, ex_ctrl.branch}, 32'd1);
    chk("beq_rd",     {27'd0, ex_rd_addr}, 32'd0);
    chk("beq_rw",     {31'd0, ex_ctrl.reg_write}, 32'd0);

    // Back-to-back stream across all formats
    for (int k = 2; k <= 12; k++) issue(k, 32'h0000_1000 + 32'(k) * 32'd4);
    idle(3);

    // Load-use: stall with flush_ex for one cycle while jalr sits in ID
    issue(12, 32'h0000_2000);
    @(negedge clk);
    drive(5, 32'h0000_2004);
    stall_id = 1'b1;
    flush_ex = 1'b1;
    #1;
    chk("lu_if_ready", {31'd0, if_ready}, 32'd0);
    after_edge();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    stall_id = 1'b0;
    flush_ex = 1'b0;
    after_edge();
    chk("lu_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_ex_pc",    ex_pc, 32'h0000_2000);
    chk("lu_ex_rd",    {27'd0, ex_rd_addr}, 32'd1);
    idle(3);

    // Plain stall for three cycles with lui in EX and sub in ID
    issue(2, 32'h0000_3000);
    issue(5, 32'h0000_3004);
    @(negedge clk);
    drive(0, 32'h0000_3008);
    stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      chk("st_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("st_ex_pc",    ex_pc, 32'h0000_3000);
      chk("st_ex_imm",   ex_imm, 32'h12345000);
      chk("st_ex_rd",    {27'd0, ex_rd_addr}, 32'd10);
      chk("st_ex_ctrl",  32'(ex_ctrl), 32'(tab(2, 32'd0).ctrl));
      chk("st_if_ready", {31'd0, if_ready}, 32'd0);
      chk("st_rs1_addr", {27'd0, rs1_addr}, 32'd8);
    end
    @(negedge clk);
    stall_id = 1'b0;
    idle(3);

    // Double flush with a valid incoming instruction, then an all-zero word
    issue(0, 32'h0000_4000);
    @(negedge clk);
    drive(5, 32'h0000_4004);
    flush_id = 1'b1;
    flush_ex = 1'b1;
    after_edge();
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_id_valid", {31'd0, dut.id_valid}, 32'd0);
    chk("fl_rs1_addr", {27'd0, rs1_addr}, 32'd0);
    issue(11, 32'h0000_4008);
    idle(1);
    after_edge();
    chk("zero_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("zero_illegal",  {31'd0, ex_ctrl.illegal}, 32'd1);
    chk("zero_rw",       {31'd0, ex_ctrl.reg_write}, 32'd0);
    idle(2);

    // Asynchronous reset between edges, then an accept right after release
    issue(6, 32'h0000_5000);
    issue(7, 32'h0000_5004);
    issue(8, 32'h0000_5008);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("arst_ex_ctrl",  32'(ex_ctrl), 32'd0);
    chk("arst_rs1_addr", {27'd0, rs1_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(4, 32'h0000_6000);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
